// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, power-of-2 FIFO, registered txd.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).

module uart_tx_buffered_chk #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    input logic                          i_push,
    input logic                          i_pop,
    input logic [$clog2(FIFO_DEPTH):0]   i_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    // FIFO occupancy can never leave 0..FIFO_DEPTH
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_pop && (i_count == {(AW + 1){1'b0}})))
                else $error("uart_tx_buffered: pop from empty FIFO");
            assert (!(i_push && !i_pop && (i_count == DEPTH_C)))
                else $error("uart_tx_buffered: push into full FIFO");
        end
    end
endmodule

module uart_tx_buffered #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_buffered: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_buffered: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_txd;
    logic            r_busy;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_tick;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_txd_next;

    assign w_tick   = (r_baud == DIV_LAST);
    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == {(AW + 1){1'b0}});
    assign w_push   = in_valid && !w_full;

    assign in_ready   = !w_full;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; a pop happens only when a new frame starts
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_next = ST_START;
                    w_pop        = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end else begin
                    w_state_next = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_state_next = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick && !w_empty) begin
                    w_state_next = ST_START;
                    w_pop        = 1'b1;
                end else if (w_tick) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM output: line level for the coming cycle, registered below
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            ST_IDLE:  w_txd_next = 1'b1;
            ST_START: w_txd_next = 1'b0;
            ST_DATA: begin
                if ((r_state == ST_DATA) && w_tick) begin
                    w_txd_next = r_shift[1];
                end else begin
                    w_txd_next = r_shift[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_next = r_parity;
`endif
            ST_STOP:  w_txd_next = 1'b1;
            default:  w_txd_next = 1'b1;
        endcase
    end

    // Baud counter, shifter and registered line outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud    <= {CW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_txd  <= w_txd_next;
            r_busy <= (w_state_next != ST_IDLE);
            if (w_pop) begin
                r_baud    <= {CW{1'b0}};
                r_bit_idx <= 3'd0;
                r_shift   <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_parity  <= even_parity(r_mem[r_rd_ptr]);
`endif
            end else begin
                if ((r_state == ST_IDLE) || w_tick) begin
                    r_baud <= {CW{1'b0}};
                end else begin
                    r_baud <= r_baud + CW'(1'b1);
                end
                if ((r_state == ST_DATA) && w_tick) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    r_shift   <= {1'b0, r_shift[7:1]};
                end
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop keeps the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1'b1);
                2'b01:   r_count <= r_count - (AW + 1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage, written only on an accepted byte
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    uart_tx_buffered_chk #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_count (r_count)
    );
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: scoreboard of queued bytes, frame monitor on txd.
module tb_uart_tx_buffered;
    localparam int DIV   = 10;
    localparam int DIV_D = 868;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;
    logic [7:0] d_in_data;
    logic       d_in_valid;
    logic       d_in_ready;
    logic       d_txd;
    logic       d_busy;
    logic [2:0] d_fifo_count;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    int         start_cyc[$];
    bit         mon_en = 1'b0;

    uart_tx_buffered #(
        .CLOCK_FREQUENCY (1_000_000),
        .BAUD_RATE       (100_000),
        .FIFO_DEPTH      (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_buffered u_dut_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (d_in_data),
        .in_valid   (d_in_valid),
        .in_ready   (d_in_ready),
        .txd        (d_txd),
        .busy       (d_busy),
        .fifo_count (d_fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i, input int nb);
        if (i == 0) return 1'b0;
        else if (i <= 8) return b[i-1];
        else if ((i == 9) && (nb == 11)) return ^b;
        else return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept_bound", 32'(n < 2000), 32'd1);
        sb.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", 32'(n < bound), 32'd1);
    endtask

    task automatic single_frame(input logic [7:0] b);
        int n;
        push(b);
        in_valid = 1'b0;
        chk("lat_count_N", 32'(fifo_count), 32'd1);
        chk("lat_txd_N", 32'(txd), 32'd1);
        chk("lat_busy_N", 32'(busy), 32'd0);
        @(negedge clk);
        chk("lat_count_N1", 32'(fifo_count), 32'd0);
        chk("lat_txd_N1", 32'(txd), 32'd0);
        chk("lat_busy_N1", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(FRAME));
        chk("end_txd", 32'(txd), 32'd1);
        chk("end_count", 32'(fifo_count), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Frame monitor: every clock of every bit must match the expected level
    initial begin : monitor
        logic [7:0] exp_b;
        bit         ok;
        logic       eb;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                start_cyc.push_back(cyc);
                chk("frame_expected", 32'(sb.size() != 0), 32'd1);
                exp_b = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                for (int b = 0; b < NB && mon_en; b++) begin
                    ok = 1'b1;
                    eb = frame_bit(exp_b, b, NB);
                    for (int k = 0; k < DIV; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (!mon_en) break;
                        if (txd !== eb || busy !== 1'b1) ok = 1'b0;
                    end
                    if (mon_en) chk($sformatf("frame_%02h_bit%0d", exp_b, b), 32'(ok), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   n0;
        int   n;
        int   bad;
        int   span;
        bit   ok;
        logic eb;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        d_in_valid = 1'b0;
        d_in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_def_txd", 32'(d_txd), 32'd1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, latency and exact frame length
        single_frame(8'h55);
`ifdef UART_TX_PARITY_EN
        single_frame(8'h07);
        single_frame(8'h03);
`endif

        // five bytes held back to back: full FIFO, contiguous frames
        repeat (3) @(negedge clk);
        start_cyc.delete();
        push(8'hA5);
        push(8'h3C);
        push(8'hFF);
        push(8'h00);
        push(8'h81);
        in_valid = 1'b0;
        chk("s2_full_ready", 32'(in_ready), 32'd0);
        chk("s2_full_count", 32'(fifo_count), 32'd4);
        wait_idle(10 * FRAME);
        chk("s2_frames", 32'(start_cyc.size()), 32'd5);
        span = (start_cyc.size() >= 5) ? (start_cyc[4] - start_cyc[0]) : -1;
        chk("s2_span", 32'(span), 32'(4 * FRAME));
        chk("s2_sb_empty", 32'(sb.size()), 32'd0);

        // full FIFO with a held byte across the stop-bit pop edge
        repeat (3) @(negedge clk);
        start_cyc.delete();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        in_valid = 1'b1;
        in_data  = 8'h66;
        n = 0;
        while (in_ready !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("s4_ready_bound", 32'(n < 2 * FRAME), 32'd1);
        chk("s4_count_after_pop", 32'(fifo_count), 32'd3);
        chk("s4_start_after_pop", 32'(txd), 32'd0);
        sb.push_back(8'h66);
        @(negedge clk);
        in_valid = 1'b0;
        chk("s4_count_refill", 32'(fifo_count), 32'd4);
        chk("s4_ready_refill", 32'(in_ready), 32'd0);
        wait_idle(8 * FRAME);
        chk("s4_frames", 32'(start_cyc.size()), 32'd6);
        chk("s4_sb_empty", 32'(sb.size()), 32'd0);

        // reset during data bit 4 of 0x0F with two bytes queued
        repeat (3) @(negedge clk);
        push(8'h0F);
        n0 = cyc;
        push(8'h11);
        push(8'h22);
        in_valid = 1'b0;
        chk("s3_queued", 32'(fifo_count), 32'd2);
        while (cyc < n0 + 1 + 5 * DIV + DIV / 2) @(negedge clk);
        chk("s3_bit4_level", 32'(txd), 32'd0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s3_txd", 32'(txd), 32'd1);
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_count", 32'(fifo_count), 32'd0);
        chk("s3_ready", 32'(in_ready), 32'd1);
        sb.delete();
        bad = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        chk("s3_quiet", 32'(bad), 32'd0);
        mon_en = 1'b1;

        // default build: 868 clocks per bit
        chk("s6_ready", 32'(d_in_ready), 32'd1);
        d_in_data  = 8'hC3;
        d_in_valid = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            ok = 1'b1;
            eb = frame_bit(8'hC3, b, NB);
            for (int k = 0; k < DIV_D; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (d_txd !== eb || d_busy !== 1'b1) ok = 1'b0;
            end
            chk($sformatf("s6_bit%0d", b), 32'(ok), 32'd1);
        end
        @(negedge clk);
        chk("s6_end_busy", 32'(d_busy), 32'd0);
        chk("s6_end_txd", 32'(d_txd), 32'd1);
        chk("s6_end_count", 32'(d_fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
